dmem_bridge: RTL and testbench
==============================

Name: dmem_bridge

Overview:
- Sits directly downstream of the load/store unit in the single-cycle core.
- Converts its byte-strobed data-memory access (address, 4-bit write strobes, pre-shifted write data, load request) into a transaction on a valid/grant/rvalid memory bus.
- Stalls the core until the transaction completes.
- Returns load data right-justified by byte offset, so the load unit's sign/zero extension works on bits [15:0]/[7:0].

Parameters:
- TIMEOUT, 255: cycles spent in REQ+RESP before the transaction is aborted with an error; range 1..65535.

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- data_addr  in  32  byte address from the load unit
- dmem_wr  in  4  byte write strobes; nonzero means store
- core_wdata  in  32  store data, already shifted to its byte lane
- core_rd  in  1  load request, held for the whole instruction
- core_rdata  out  32  load data, shifted right by data_addr[1:0]*8
- core_stall  out  1  freeze PC/regfile while high
- core_err  out  1  one-cycle pulse: timeout or illegal request
- bus_req  out  1  transaction valid
- bus_we  out  1  1 = write
- bus_addr  out  32  word address {addr[31:2],2'b00}
- bus_wdata  out  32  write data
- bus_be  out  4  byte enables
- bus_gnt  in  1  slave accepts request this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data, word-aligned

Behaviour:
- Reset values: state IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, core_rdata=0, core_err=0, timeout counter=0. Reset mid-transaction abandons it immediately with no bus completion expected.
- access = core_rd | (dmem_wr!=0). illegal = core_rd & (dmem_wr!=0).
- core_stall (combinational) = access & (state!=DONE).
- States:
  - IDLE:
    - access & !illegal: capture bus_addr, bus_we=(dmem_wr!=0), bus_be=(we ? dmem_wr : 4'b1111), bus_wdata=core_wdata, offset=data_addr[1:0]; go to REQ.
    - illegal: go to DONE with err_flag set; no bus cycle.
  - REQ:
    - bus_req=1; outputs are held stable until bus_gnt.
    - gnt & we: go to DONE.
    - gnt & !we & bus_rvalid (same cycle): latch rdata; go to DONE.
    - gnt & !we & !bus_rvalid: go to RESP.
  - RESP: bus_req=0; on bus_rvalid, latch rdata and go to DONE.
  - DONE:
    - core_stall=0 for exactly one cycle.
    - core_rdata = latched word >> (offset*8), zero-filled.
    - core_err = err_flag.
    - Always go to IDLE.
- Timeout:
  - Counter clears on IDLE->REQ and increments each cycle in REQ/RESP.
  - When it equals TIMEOUT-1 with no completing event, go to DONE with err_flag=1 and core_rdata=0.
  - A late bus_rvalid arriving in IDLE is ignored.
- core_rdata holds its value outside DONE. It updates only when entering DONE from a read; writes and errors leave it at 0.
- Back-to-back accesses: after DONE the core advances. A new access then spends one IDLE cycle before REQ. Minimum core stall: 2 cycles for a write, 2 cycles for a read (rvalid with gnt).
- bus_rvalid/bus_gnt outside REQ/RESP: ignored.

Test Plan:
- Reset: assert rst_n=0 mid-REQ -> bus_req=0, state IDLE, core_stall follows access only, core_rdata=0.
- Word store: data_addr=0x1000_0008, dmem_wr=4'b1111, core_wdata=0xDEADBEEF, gnt on first REQ cycle -> bus_addr=0x1000_0008, bus_be=1111, bus_we=1; stall high 2 cycles, DONE 1 cycle, err=0.
- Byte load at offset 3 with wait states: data_addr=0x2003, core_rd=1, gnt after 2 REQ cycles, rvalid 3 cycles later with bus_rdata=0xA1B2C3D4 -> bus_addr=0x2000, bus_be=1111, core_rdata=0x000000A1 in DONE.
- Halfword store at offset 2: dmem_wr=4'b1100, core_wdata=0x55AA0000 -> bus_be=1100, bus_wdata=0x55AA0000 held stable across 4 ungranted REQ cycles.
- Timeout: TIMEOUT=8, load with no gnt -> bus_req high exactly 8 cycles, then DONE with core_err=1 and core_rdata=0; a later stray rvalid has no effect.
- Illegal request: core_rd=1 with dmem_wr=4'b0001 -> no bus_req, DONE after 1 cycle with core_err=1. Gnt+rvalid in the same cycle -> DONE next cycle.

Source files
------------

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns the core's byte-strobed load/store into a valid/grant/rvalid
// bus transaction, stalling the core until it completes or times out.
module dmem_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_addr,
  input  logic [3:0]  dmem_wr,
  input  logic [31:0] core_wdata,
  input  logic        core_rd,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        core_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0]  state_q, state_d;
  logic        we_q, we_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] cnt_q, cnt_d;
  logic        store, access, illegal, expired;
  logic [31:0] shifted;
  assign store   = dmem_wr != 4'b0000;
  assign access  = core_rd | store;
  assign illegal = core_rd & store;
  assign expired = cnt_q == 16'(TIMEOUT - 1);
  // Right-justify the addressed byte/halfword so the load unit extends from bit 0.
  assign shifted = bus_rdata >> {off_q, 3'b000};
  assign core_stall = access & (state_q != DONE);
  assign core_err   = (state_q == DONE) & err_q;
  assign bus_req    = state_q == REQ;
  assign core_rdata = rdata_q;
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_be     = be_q;
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (illegal) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (access) begin
          state_d = REQ;
          err_d   = 1'b0;
          cnt_d   = '0;
          we_d    = store;
          be_d    = store ? dmem_wr : 4'b1111;
          addr_d  = {data_addr[31:2], 2'b00};
          wdata_d = core_wdata;
          off_d   = data_addr[1:0];
        end
      end
      REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (bus_gnt & (we_q | bus_rvalid)) begin
          state_d = DONE;
          rdata_d = we_q ? 32'd0 : shifted;
        end else if (expired) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (bus_gnt) begin
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d = cnt_q + 16'd1;
        if (bus_rvalid) begin
          state_d = DONE;
          rdata_d = shifted;
        end else if (expired) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed checks of dmem_bridge with TIMEOUT=8.
module tb_dmem_bridge;
  logic        clk, rst_n;
  logic [31:0] data_addr, core_wdata, core_rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  dmem_wr, bus_be;
  logic        core_rd, core_stall, core_err, bus_req, bus_we, bus_gnt, bus_rvalid;
  int checks = 0, errors = 0, n;
  dmem_bridge #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .data_addr(data_addr), .dmem_wr(dmem_wr),
    .core_wdata(core_wdata), .core_rd(core_rd), .core_rdata(core_rdata),
    .core_stall(core_stall), .core_err(core_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in;
    data_addr = '0; dmem_wr = '0; core_wdata = '0; core_rd = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
  endtask
  initial begin
    idle_in();
    rst_n = 1'b0;
    step(); step();
    chk("rst_req", bus_req, 0);
    chk("rst_rdata", core_rdata, 0);
    chk("rst_stall", core_stall, 0);
    chk("rst_err", core_err, 0);
    chk("rst_addr", bus_addr, 0);
    rst_n = 1'b1;
    step();
    // word store, granted on first REQ cycle
    data_addr = 32'h1000_0008; dmem_wr = 4'b1111; core_wdata = 32'hDEADBEEF;
    #1 chk("ws_stall_idle", core_stall, 1);
    step();
    chk("ws_req", bus_req, 1);
    chk("ws_addr", bus_addr, 32'h1000_0008);
    chk("ws_be", bus_be, 4'b1111);
    chk("ws_we", bus_we, 1);
    chk("ws_wdata", bus_wdata, 32'hDEADBEEF);
    chk("ws_stall_req", core_stall, 1);
    bus_gnt = 1'b1;
    step();
    chk("ws_done_stall", core_stall, 0);
    chk("ws_done_err", core_err, 0);
    chk("ws_done_req", bus_req, 0);
    idle_in();
    step();
    // byte load at offset 3 with wait states
    data_addr = 32'h0000_2003; core_rd = 1'b1;
    step();
    chk("bl_addr", bus_addr, 32'h0000_2000);
    chk("bl_be", bus_be, 4'b1111);
    chk("bl_we", bus_we, 0);
    step();
    chk("bl_req2", bus_req, 1);
    step();
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    chk("bl_resp_req", bus_req, 0);
    chk("bl_resp_stall", core_stall, 1);
    step(); step();
    bus_rvalid = 1'b1; bus_rdata = 32'hA1B2C3D4;
    step();
    chk("bl_rdata", core_rdata, 32'h0000_00A1);
    chk("bl_stall", core_stall, 0);
    chk("bl_err", core_err, 0);
    idle_in();
    step();
    chk("bl_hold", core_rdata, 32'h0000_00A1);
    // halfword store held across ungranted REQ cycles
    data_addr = 32'h0000_3002; dmem_wr = 4'b1100; core_wdata = 32'h55AA0000;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("hs_req", bus_req, 1);
      chk("hs_be", bus_be, 4'b1100);
      chk("hs_wdata", bus_wdata, 32'h55AA0000);
      chk("hs_addr", bus_addr, 32'h0000_3000);
      step();
    end
    bus_gnt = 1'b1;
    step();
    chk("hs_done_stall", core_stall, 0);
    chk("hs_rdata_zero", core_rdata, 0);
    idle_in();
    step();
    // timeout on a load that is never granted
    data_addr = 32'h0000_4000; core_rd = 1'b1;
    step();
    n = 0;
    for (int i = 0; i < 20 && bus_req; i++) begin
      n++;
      step();
    end
    chk("to_req_cycles", n, 8);
    chk("to_err", core_err, 1);
    chk("to_stall", core_stall, 0);
    chk("to_rdata", core_rdata, 0);
    idle_in();
    step();
    chk("to_err_pulse", core_err, 0);
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    step();
    bus_rvalid = 1'b0;
    step();
    chk("stray_rdata", core_rdata, 0);
    chk("stray_err", core_err, 0);
    chk("stray_req", bus_req, 0);
    // illegal request: load and store together
    core_rd = 1'b1; dmem_wr = 4'b0001; data_addr = 32'h0000_4444;
    #1 chk("il_stall", core_stall, 1);
    step();
    chk("il_req", bus_req, 0);
    chk("il_err", core_err, 1);
    chk("il_stall_done", core_stall, 0);
    idle_in();
    step();
    // grant and rvalid together complete in one REQ cycle
    data_addr = 32'h0000_5001; core_rd = 1'b1;
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1122_3344;
    step();
    chk("gr_req", bus_req, 1);
    chk("gr_stall", core_stall, 1);
    step();
    chk("gr_rdata", core_rdata, 32'h0011_2233);
    chk("gr_stall_done", core_stall, 0);
    chk("gr_err", core_err, 0);
    idle_in();
    step();
    // asynchronous reset in the middle of a REQ
    data_addr = 32'h0000_6000; core_rd = 1'b1;
    step();
    chk("mr_req_before", bus_req, 1);
    #2 rst_n = 1'b0;
    #1 chk("mr_req", bus_req, 0);
    chk("mr_rdata", core_rdata, 0);
    chk("mr_addr", bus_addr, 0);
    chk("mr_stall_access", core_stall, 1);
    core_rd = 1'b0;
    #1 chk("mr_stall_noaccess", core_stall, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("mr_idle_req", bus_req, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
